if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the instruction buffer entries and the maximum number of in-flight requests; legal values are 2..8.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 The block SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 The block SHALL have port imem_req_addr  output  64  fetch address.
REQ-008 The block SHALL have port imem_resp_valid  input  1  instruction returned; in order, at least 1 cycle after acceptance.
REQ-009 The block SHALL have port imem_resp_data  input  32  returned instruction.
REQ-010 The block SHALL have port if_stall  input  1  downstream IF/ID register is not consuming this cycle.
REQ-011 The block SHALL have port redirect_valid  input  1  control transfer resolved in EXE.
REQ-012 The block SHALL have port redirect_pc  input  64  new fetch target.
REQ-013 The block SHALL have port out_valid  output  1  out_pc/out_inst hold a valid instruction.
REQ-014 The block SHALL have port out_pc  output  64  PC of the presented instruction.
REQ-015 The block SHALL have port out_inst  output  32  presented instruction; 32'h0000_0013 (NOP) when out_valid=0.
REQ-016 The block SHALL have port if_ready  output  1  equals out_valid; drives the pipeline's IF ready.

Function
REQ-017 The block SHALL implement FSM states BOOT, FETCH and FLUSH.
REQ-018 The block SHALL make the BOOT->FETCH transition unconditionally one cycle after reset release, with no request issued in BOOT.
REQ-019 The block SHALL, in FETCH, assert imem_req_valid iff inflight + occupancy < DEPTH, with imem_req_addr = fetch PC.
REQ-020 The block SHALL advance the fetch PC by 4 on a request handshake (valid & ready), wrapping modulo 2^64.
REQ-021 The block SHALL push each non-stale response into the FIFO tagged with its request PC; the response never overflows because of REQ-019.
REQ-022 The block SHALL present the FIFO head on out_*, and SHALL pop it when out_valid=1 and if_stall=0.
REQ-023 The block SHALL accept a push into an empty FIFO without bypass, so response-to-out_valid latency is 1 cycle.
REQ-024 The block SHALL support a push and a pop in the same cycle, leaving occupancy unchanged.
REQ-025 The block SHALL, on redirect_valid=1:
  - set fetch PC to {redirect_pc[63:2],2'b00};
  - clear the FIFO;
  - set stale = inflight, including any request handshaking that same cycle;
  - suppress that cycle's pop;
  - enter FLUSH if stale>0, else FETCH.
REQ-026 The block SHALL, in FLUSH, hold imem_req_valid=0, discard each response while decrementing stale, and enter FETCH in the cycle after stale reaches 0.
REQ-027 The block SHALL, on a redirect during FLUSH, reload the PC only and leave stale unchanged.
REQ-028 The block SHALL give redirect priority over the same-cycle pop, push and PC increment.
REQ-029 The block SHALL treat if_stall as gating the pop only; fetching continues until the FIFO credits are exhausted.
REQ-030 The block SHALL keep the inflight and stale counters $clog2(DEPTH+1) bits wide, never underflowing; a response arriving with inflight=0 SHALL be ignored.

Reset
REQ-031 The block SHALL, while rst=1, asynchronously force:
  - state=BOOT, PC=RESET_PC;
  - FIFO empty, inflight=0, stale=0;
  - imem_req_valid=0, out_valid=0, if_ready=0;
  - out_pc=0, out_inst=NOP.
REQ-032 The block SHALL, on reset asserted mid-operation, discard all in-flight responses; the environment guarantees memory is also reset.

Verification
REQ-033 Reset release with memory always ready and 1-cycle response SHALL produce first request addr 0x80000000 in cycle 2, out_valid with out_pc=0x80000000 in cycle 4, and consecutive PCs +4 thereafter.
REQ-034 if_stall held high for 10 cycles SHALL yield exactly DEPTH requests and then imem_req_valid=0 with out_* stable; releasing it SHALL resume with no lost or duplicated PC.
REQ-035 redirect_valid with redirect_pc=0x80001003 and 2 requests in flight SHALL discard the next 2 responses (never appearing on out_*), issue the next request at 0x80001000, and present 0x80001000 first.
REQ-036 A redirect coinciding with a pop and a response push SHALL leave out_valid=0 the following cycle and FIFO occupancy 0.
REQ-037 A redirect with PC=0xFFFFFFFFFFFFFFFC SHALL cause the next request to wrap to address 0x0.
REQ-038 rst asserted while 2 requests are in flight SHALL drop out_valid and imem_req_valid to 0 immediately, and after release fetch SHALL restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Small generic FIFO with synchronous clear; head is visible combinationally.
// Latency: a write is visible at the head on the following cycle (no bypass).
// Backpressure: writes are dropped when full unless a read frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign rd_ok  = rd_rdy & rd_vld;
    assign wr_ok  = wr_vld & ((count != CW'(DEPTH)) | rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_ok && !rd_ok)      count <= count + CW'(1);
            else if (!wr_ok && rd_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Instruction fetch controller: issues sequential fetches, buffers responses, handles redirects.
// Latency: response to out_valid is 1 cycle; first request 2 cycles after reset release.
// Backpressure: if_stall holds the head; requests stop once inflight + buffered reaches DEPTH.
module if_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        if_ready
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          SW  = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q;
    logic [63:0]   resp_pc_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] stale_q, stale_d;
    logic [CW-1:0] occ;
    logic [95:0]   head_dat;
    logic [63:0]   redirect_tgt;
    logic          req_hs;
    logic          resp_take;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign req_hs    = imem_req_valid & imem_req_ready;
    // Responses with nothing outstanding are spurious and ignored.
    assign resp_take = imem_resp_valid & (inflight_q != '0);
    assign resp_drop = resp_take & (stale_q != '0);
    assign push      = resp_take & ~resp_drop & ~redirect_valid & (state_q == FETCH);
    assign pop       = out_valid & ~if_stall & ~redirect_valid;

    always_comb begin
        inflight_d = inflight_q;
        if (req_hs && !resp_take)      inflight_d = inflight_q + CW'(1);
        else if (!req_hs && resp_take) inflight_d = inflight_q - CW'(1);
    end

    // Everything still outstanding after a redirect cycle belongs to the old path.
    always_comb begin
        stale_d = stale_q;
        if (redirect_valid && state_q != FLUSH) stale_d = inflight_d;
        else if (resp_drop)                     stale_d = stale_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = (redirect_valid && stale_d != '0) ? FLUSH : FETCH;
            FLUSH:   state_d = (stale_d == '0) ? FETCH : FLUSH;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if (state_q == FETCH)
            imem_req_valid = (SW'(inflight_q) + SW'(occ)) < SW'(DEPTH);
    end

    assign imem_req_addr = pc_q;

    // resp_pc_q tracks the PC of the next non-stale response; responses return in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            if (redirect_valid) begin
                pc_q      <= redirect_tgt;
                resp_pc_q <= redirect_tgt;
            end else begin
                if (req_hs) pc_q      <= pc_q + 64'd4;
                if (push)   resp_pc_q <= resp_pc_q + 64'd4;
            end
        end
    end

    sync_fifo #(
        .WIDTH (96),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk    (clk),
        .rst    (rst),
        .clr    (redirect_valid),
        .wr_vld (push),
        .wr_dat ({resp_pc_q, imem_resp_data}),
        .rd_rdy (pop),
        .rd_vld (out_valid),
        .rd_dat (head_dat),
        .count  (occ)
    );

    assign if_ready = out_valid;
    assign out_pc   = out_valid ? head_dat[95:32] : 64'd0;
    assign out_inst = out_valid ? head_dat[31:0]  : NOP;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with an in-order memory model of programmable latency.
module tb_if_fetch_ctrl;
    localparam logic [63:0] B     = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        if_ready;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(B), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_stall        (if_stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .if_ready        (if_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int cyc      = 0;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        rv;
        logic [63:0] ra;
        logic        ov;
        logic [63:0] opc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0003;
    endfunction

    function automatic vec_t mk(input logic rv, input logic [63:0] ra,
                                input logic ov, input logic [63:0] opc);
        vec_t v;
        v.stall = 1'b0;
        v.redir = 1'b0;
        v.rpc   = 64'd0;
        v.rv    = rv;
        v.ra    = ra;
        v.ov    = ov;
        v.opc   = opc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        if_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic skip_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // In-order memory: a request accepted in cycle c answers in cycle c + mem_lat.
    initial begin
        mreq_t m;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                m.addr = imem_req_addr;
                m.due  = cyc + mem_lat;
                mq.push_back(m);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                mq.delete();
                imem_resp_valid = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = inst_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          hs_cnt, stable, npop, stale_seen;
        int          first_req_cyc, first_out_cyc;
        logic [63:0] exp_pc, first_req_addr, first_out_pc;
        logic [31:0] first_out_inst;

        // Steady fetch after reset, memory always ready, 1-cycle latency.
        tbl[0]  = mk(1'b0, 64'd0,      1'b0, 64'd0);
        tbl[1]  = mk(1'b1, B,          1'b0, 64'd0);
        tbl[2]  = mk(1'b1, B + 64'h4,  1'b0, 64'd0);
        tbl[3]  = mk(1'b0, 64'd0,      1'b1, B);
        tbl[4]  = mk(1'b1, B + 64'h8,  1'b1, B + 64'h4);
        tbl[5]  = mk(1'b1, B + 64'hC,  1'b0, 64'd0);
        tbl[6]  = mk(1'b0, 64'd0,      1'b1, B + 64'h8);
        tbl[7]  = mk(1'b1, B + 64'h10, 1'b1, B + 64'hC);
        tbl[8]  = mk(1'b1, B + 64'h14, 1'b0, 64'd0);
        tbl[9]  = mk(1'b0, 64'd0,      1'b1, B + 64'h10);
        tbl[10] = mk(1'b1, B + 64'h18, 1'b1, B + 64'h14);

        imem_req_ready = 1'b1;
        rst            = 1'b1;
        if_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        #1;
        chk("reset req_valid", 64'(imem_req_valid), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset if_ready",  64'(if_ready), 64'd0);
        chk("reset out_pc",    out_pc, 64'd0);
        chk("reset out_inst",  64'(out_inst), 64'(NOP));

        // Table: cycle-accurate start-up and steady state.
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if_stall       = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("tbl[%0d] req_valid", i), 64'(imem_req_valid), 64'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("tbl[%0d] req_addr", i), imem_req_addr, tbl[i].ra);
            chk($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl[%0d] if_ready", i),  64'(if_ready), 64'(tbl[i].ov));
            chk($sformatf("tbl[%0d] out_pc", i),    out_pc, tbl[i].opc);
            chk($sformatf("tbl[%0d] out_inst", i),  64'(out_inst),
                64'(tbl[i].ov ? inst_of(tbl[i].opc) : NOP));
            step();
        end

        // Stall from reset: DEPTH requests, then credits exhausted, head stable.
        do_reset();
        if_stall = 1'b1;
        hs_cnt   = 0;
        stable   = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) hs_cnt++;
            if (c >= 4 && out_valid && out_pc == B) stable++;
            step();
        end
        chk("stall request count", 64'(hs_cnt), 64'(DEPTH));
        chk("stall head stable cycles", 64'(stable), 64'd9);
        @(negedge clk);
        chk("stall req_valid", 64'(imem_req_valid), 64'd0);
        chk("stall out_valid", 64'(out_valid), 64'd1);
        chk("stall out_inst",  64'(out_inst), 64'(inst_of(B)));
        step();
        if_stall = 1'b0;
        exp_pc   = B;
        npop     = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk($sformatf("resume pop %0d pc", npop), out_pc, exp_pc);
                exp_pc = exp_pc + 64'd4;
                npop++;
            end
            step();
        end
        chk("resume pop count >= 10", 64'(npop >= 10), 64'd1);

        // Redirect with two requests outstanding.
        mem_lat = 4;
        do_reset();
        skip_cycles(3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1003;
        @(negedge clk);
        chk("redir c4 req_valid", 64'(imem_req_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        first_req_cyc  = 0;
        first_out_cyc  = 0;
        first_req_addr = 64'd0;
        first_out_pc   = 64'd0;
        first_out_inst = 32'd0;
        stale_seen     = 0;
        for (int c = 5; c <= 20; c++) begin
            @(negedge clk);
            if (imem_req_valid && first_req_cyc == 0) begin
                first_req_cyc  = c;
                first_req_addr = imem_req_addr;
            end
            if (out_valid && (out_pc == B || out_pc == B + 64'h4)) stale_seen++;
            if (out_valid && first_out_cyc == 0) begin
                first_out_cyc  = c;
                first_out_pc   = out_pc;
                first_out_inst = out_inst;
            end
            step();
        end
        chk("redir first req cycle", 64'(first_req_cyc), 64'd8);
        chk("redir first req addr",  first_req_addr, 64'h0000_0000_8000_1000);
        chk("redir first out cycle", 64'(first_out_cyc), 64'd13);
        chk("redir first out pc",    first_out_pc, 64'h0000_0000_8000_1000);
        chk("redir first out inst",  64'(first_out_inst), 64'(inst_of(64'h0000_0000_8000_1000)));
        chk("redir stale presented", 64'(stale_seen), 64'd0);

        // Redirect coinciding with a pop and a push.
        mem_lat = 1;
        do_reset();
        skip_cycles(3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_4000_0000;
        @(negedge clk);
        chk("coinc c4 out_valid", 64'(out_valid), 64'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc c5 out_valid", 64'(out_valid), 64'd0);
        chk("coinc c5 req_valid", 64'(imem_req_valid), 64'd1);
        chk("coinc c5 req_addr",  imem_req_addr, 64'h0000_0000_4000_0000);
        step();
        @(negedge clk);
        chk("coinc c6 out_valid", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("coinc c7 out_valid", 64'(out_valid), 64'd1);
        chk("coinc c7 out_pc",    out_pc, 64'h0000_0000_4000_0000);
        step();

        // Redirect to the top of the address space; next fetch wraps to 0.
        do_reset();
        skip_cycles(2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap c4 req_valid", 64'(imem_req_valid), 64'd0);
        chk("wrap c4 out_valid", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("wrap c5 req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap c6 req_valid", 64'(imem_req_valid), 64'd1);
        chk("wrap c6 req_addr",  imem_req_addr, 64'd0);
        step();
        @(negedge clk);
        chk("wrap c7 out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap c8 out_pc", out_pc, 64'd0);
        step();

        // Asynchronous reset mid-operation while presenting and requesting.
        do_reset();
        skip_cycles(4);
        @(negedge clk);
        chk("arst pre out_valid", 64'(out_valid), 64'd1);
        chk("arst pre req_valid", 64'(imem_req_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst req_valid", 64'(imem_req_valid), 64'd0);
        chk("arst out_pc",    out_pc, 64'd0);
        chk("arst out_inst",  64'(out_inst), 64'(NOP));

        // Reset with two requests outstanding, then restart from RESET_PC.
        mem_lat = 2;
        do_reset();
        skip_cycles(3);
        @(negedge clk);
        chk("arst2 c4 req_valid", 64'(imem_req_valid), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst2 out_valid", 64'(out_valid), 64'd0);
        chk("arst2 req_valid", 64'(imem_req_valid), 64'd0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("restart c1 req_valid", 64'(imem_req_valid), 64'd0);
        step();
        @(negedge clk);
        chk("restart c2 req_valid", 64'(imem_req_valid), 64'd1);
        chk("restart c2 req_addr",  imem_req_addr, B);
        step();
        skip_cycles(2);
        @(negedge clk);
        chk("restart c5 out_valid", 64'(out_valid), 64'd1);
        chk("restart c5 out_pc",    out_pc, B);
        chk("restart c5 out_inst",  64'(out_inst), 64'(inst_of(B)));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
